// File: rtl/key_edge_pkg.sv
// Shared types and sizing helpers for the key edge detector.
package key_edge_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    // Debounce counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_edge_channel.sv
// One input channel: synchroniser, debounce counter, level, edge pulse, sticky flag.
module key_edge_channel
    import key_edge_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  edge_mode_e mode,
    input  logic       event_clr,
    output logic       level_out,
    output logic       edge_pulse,
    output logic       event_flag,
    output logic       event_flag_nxt
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   flag_q, flag_d;
    logic                   sync_out;
    logic                   toggle;
    logic                   dir_ok;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        toggle  = 1'b0;
        if (sync_out == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            toggle  = 1'b1;
            level_d = sync_out;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Mode is only consulted on the cycle the level actually toggles.
    always_comb begin
        dir_ok = 1'b0;
        case (mode)
            EDGE_RISE: dir_ok = sync_out;
            EDGE_FALL: dir_ok = ~sync_out;
            EDGE_BOTH: dir_ok = 1'b1;
            default:   dir_ok = 1'b0;
        endcase
        pulse_d = toggle & dir_ok;
        flag_d  = pulse_d | (flag_q & ~event_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
        end
    end

    assign level_out      = level_q;
    assign edge_pulse     = pulse_q;
    assign event_flag     = flag_q;
    assign event_flag_nxt = flag_d;

endmodule

// File: rtl/key_edge_detector.sv
// Multi-channel key synchroniser/debouncer/edge detector with a registered any-event summary.
module key_edge_detector
    import key_edge_pkg::*;
#(
    parameter int CH              = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   din,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   event_clr,
    output logic [CH-1:0]   level_out,
    output logic [CH-1:0]   edge_pulse,
    output logic [CH-1:0]   event_flag,
    output logic            any_event
);

    if (CH < 1) begin : g_bad_ch
        $error("CH must be >= 1");
    end

    logic [CH-1:0] flag_nxt;
    logic          any_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        key_edge_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .din            (din[i]),
            .mode           (edge_mode_e'(mode[2*i +: 2])),
            .event_clr      (event_clr[i]),
            .level_out      (level_out[i]),
            .edge_pulse     (edge_pulse[i]),
            .event_flag     (event_flag[i]),
            .event_flag_nxt (flag_nxt[i])
        );
    end

    // Built from next-state flags so any_event lines up with event_flag.
    always_ff @(posedge clk) begin
        if (rst) any_q <= 1'b0;
        else     any_q <= |flag_nxt;
    end

    assign any_event = any_q;

endmodule

// File: doc/key_edge_detector.md
Name: key_edge_detector

Overview:
Multi-channel synchroniser, debouncer and edge detector for push-buttons and other slow asynchronous inputs. It is the parametrised successor to the single-channel rising-edge detector. Channel count, synchroniser depth and debounce time are parameters, and each channel has its own run-time edge mode (rise/fall/both/none). Each channel outputs a debounced level, a one-cycle edge pulse and a sticky event flag with clear. It sits between board-level key inputs and LED/control logic.

Parameters:
CH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, flip-flops in each input synchroniser chain (>=2)
DEBOUNCE_CYCLES, 20000, consecutive cycles a synchronised input must differ from the stable level before it is accepted (>=1)

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  reset, synchronous, active-high; clears all state
din  input  CH  raw asynchronous inputs, one bit per channel
mode  input  2*CH  per-channel edge mode; channel i uses bits [2i+1:2i]; 00 none, 01 rise, 10 fall, 11 both
event_clr  input  CH  per-channel clear for event_flag; level-sensitive, sampled each cycle
level_out  output  CH  debounced stable level per channel
edge_pulse  output  CH  one-cycle pulse per detected, mode-enabled edge
event_flag  output  CH  sticky per-channel event indicator
any_event  output  1  OR of all event_flag bits, registered

Behaviour:
- Reset: synchronous, active-high. While rst=1 at a clk edge, all of the following clear to 0: sync chains, debounce counters, level_out, edge_pulse, event_flag, any_event. Reset mid-debounce discards the partial count.
- Synchroniser: din[i] passes through SYNC_STAGES flops. sync_out is the last stage.
- Debounce, evaluated per channel on each clk edge:
  - sync_out == level_out: counter <= 0.
  - sync_out != level_out and counter == DEBOUNCE_CYCLES-1: level_out <= sync_out, counter <= 0.
  - Otherwise: counter <= counter+1.
- Counter width is clog2(DEBOUNCE_CYCLES), minimum 1 bit. The counter never wraps.
- Glitch rejection: any disagreement shorter than DEBOUNCE_CYCLES consecutive cycles resets the counter, and level_out does not change.
- Latency: din[i] changes and settles before clk edge k. level_out[i] and edge_pulse[i] update at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
- edge_pulse[i] is registered. It is set on the edge where level_out[i] toggles, if mode[i] permits that direction (01 for 0->1, 10 for 1->0, 11 for either). It is 0 on every other cycle, so it is exactly one cycle wide.
- mode is sampled only on the toggle edge. Changing mode never creates or cancels a pulse retroactively. Mode 00 still updates level_out.
- event_flag[i]:
  - Set on the same edge edge_pulse[i] is set.
  - Cleared by event_clr[i]=1.
  - Simultaneous set and clear: set wins, so no event is lost.
  - Clear with no pending event has no effect.
- any_event is registered from the next-state OR of event_flag, so it is aligned with event_flag.
- Input held high through reset: after release, level_out rises and a rising edge is reported (mode permitting) after SYNC_STAGES+DEBOUNCE_CYCLES-1 cycles.
- Channels are fully independent. No cross-channel arbitration.
- Parameter violations (CH<1, SYNC_STAGES<2, DEBOUNCE_CYCLES<1) cause an elaboration-time error.

Decomposition:
- Package key_edge_pkg:
  - typedef enum logic [1:0] edge_mode_e: EDGE_NONE=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11.
  - Localparam helper for debounce counter width.
- Sub-module key_edge_channel: one channel's synchroniser, debounce counter, level register, pulse and sticky flag. It is instantiated CH times in a generate loop.
- The top level handles only mode slicing and any_event.

Test Plan:
- Bench parameters CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Rise detect: ch0 mode=01, din[0] 0->1 before edge k -> level_out[0]=1 and edge_pulse[0]=1 for exactly one cycle after edge k+5; event_flag[0]=1, any_event=1 from the same edge.
- Glitch reject: din[1] high for 3 cycles then low -> level_out[1], edge_pulse[1] and event_flag[1] stay 0. A 4-cycle-plus-sync-aligned high is accepted.
- Mode filtering: ch2 mode=10, din[2] 0->1->0 with each level held 10 cycles -> one pulse, only on the falling toggle. Mode=00 gives no pulse, but level_out follows din.
- Set/clear collision: event_clr[3]=1 held on the same edge edge_pulse[3] asserts (mode=11) -> event_flag[3]=1 afterwards. Clear one cycle later -> event_flag[3]=0, any_event=0 if no other flags are set.
- Reset mid-debounce: din[0] toggles, rst=1 for 1 cycle at count 2 -> all outputs 0 next cycle. din[0] held 1 -> rising pulse 5 cycles after rst deasserts.
- Simultaneous channels: all four din rise on the same edge, mode=01 -> all four edge_pulse bits assert on the same cycle, and event_flag=4'b1111.
